// File: rtl/etch_cursor_ctrl.sv
// etch_cursor_ctrl: rotary-step cursor tracker that issues framebuffer pixel writes and full-screen clear sweeps
// Optional ETCH_CURSOR_WRAP_EN: axes wrap modulo (MAX+1) instead of clamping.
module etch_cursor_ctrl #(
  parameter int   X_W   = 10,
  parameter int   Y_W   = 9,
  parameter int   X_MAX = 639,
  parameter int   Y_MAX = 479,
  parameter logic INK   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_cw,
  input  logic           x_ccw,
  input  logic           y_cw,
  input  logic           y_ccw,
  input  logic           clear_req,
  input  logic           pix_ready,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_color,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
  localparam int XS = X_W + 5;
  localparam int YS = Y_W + 5;
  localparam logic signed [XS-1:0] XM  = XS'(X_MAX);
  localparam logic signed [XS-1:0] XM1 = XS'(X_MAX + 1);
  localparam logic signed [YS-1:0] YM  = YS'(Y_MAX);
  localparam logic signed [YS-1:0] YM1 = YS'(Y_MAX + 1);
  state_t state;
  logic signed [3:0] pend_x, pend_y, npx, npy;
  logic signed [1:0] sx, sy;
  logic signed [XS-1:0] x_sum;
  logic signed [YS-1:0] y_sum;
  logic [X_W-1:0] x_new;
  logic [Y_W-1:0] y_new;
  logic clr_lat, move, moved, x_last, y_last;
  function automatic logic signed [3:0] sat4(input logic signed [3:0] p, input logic signed [1:0] s);
    logic signed [4:0] t;
    t = {p[3], p} + {{3{s[1]}}, s};
    return t > 5'sd7 ? 4'sd7 : t < -5'sd8 ? -4'sd8 : t[3:0];
  endfunction
  assign sx = $signed({1'b0, x_cw}) - $signed({1'b0, x_ccw});
  assign sy = $signed({1'b0, y_cw}) - $signed({1'b0, y_ccw});
  assign npx = sat4(pend_x, sx);
  assign npy = sat4(pend_y, sy);
  assign x_last = pix_x == X_W'(X_MAX);
  assign y_last = pix_y == Y_W'(Y_MAX);
  always_comb begin
    x_sum = $signed({5'b0, cursor_x}) + {{(XS-4){pend_x[3]}}, pend_x} + {{(XS-2){sx[1]}}, sx};
    y_sum = $signed({5'b0, cursor_y}) + {{(YS-4){pend_y[3]}}, pend_y} + {{(YS-2){sy[1]}}, sy};
`ifdef ETCH_CURSOR_WRAP_EN
    x_new = x_sum[XS-1] ? X_W'(x_sum + XM1) : x_sum > XM ? X_W'(x_sum - XM1) : X_W'(x_sum);
    y_new = y_sum[YS-1] ? Y_W'(y_sum + YM1) : y_sum > YM ? Y_W'(y_sum - YM1) : Y_W'(y_sum);
`else
    x_new = x_sum[XS-1] ? '0 : x_sum > XM ? X_W'(X_MAX) : X_W'(x_sum);
    y_new = y_sum[YS-1] ? '0 : y_sum > YM ? Y_W'(Y_MAX) : Y_W'(y_sum);
`endif
    move  = sx != 0 || sy != 0 || pend_x != 0 || pend_y != 0;
    moved = x_new != cursor_x || y_new != cursor_y;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cursor_x  <= X_W'(X_MAX >> 1);
      cursor_y  <= Y_W'(Y_MAX >> 1);
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= 1'b0;
      busy      <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      clr_lat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_lat || clear_req) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            pix_valid <= 1'b1;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= ~INK;
            clr_lat   <= 1'b0;
            pend_x    <= npx;
            pend_y    <= npy;
          end else if (move) begin
            pend_x <= '0;
            pend_y <= '0;
            if (moved) begin
              state     <= DRAW;
              busy      <= 1'b1;
              cursor_x  <= x_new;
              cursor_y  <= y_new;
              pix_x     <= x_new;
              pix_y     <= y_new;
              pix_color <= INK;
              pix_valid <= 1'b1;
            end
          end
        end
        DRAW: begin
          pend_x <= npx;
          pend_y <= npy;
          if (clear_req) clr_lat <= 1'b1;
          if (pix_ready) begin
            pix_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        CLEAR: begin
          pend_x <= npx;
          pend_y <= npy;
          if (clear_req) clr_lat <= 1'b1;
          if (pix_ready) begin
            if (x_last && y_last) begin
              pix_valid <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
            end else if (x_last) begin
              pix_x <= '0;
              pix_y <= pix_y + 1'b1;
            end else begin
              pix_x <= pix_x + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
